// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder controller.
package adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/rca4_cell.sv
// Combinational 4-bit ripple-carry adder cell built from full-adder equations.
module rca4_cell
   import adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s,
   output logic                co
);

   always_comb begin
      logic [NIBBLE_W:0] c;
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < NIBBLE_W; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      co = c[NIBBLE_W];
   end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-nibble adder that time-shares one rca4_cell, LSB nibble first.
// Define ADDER_SUB_EN to add the sub port (A-B via inverted B and carry-in 1).
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one nibble per edge, carry chained through cy_q
module nibble_serial_adder_ctrl
   import adder_pkg::*;
#(
   parameter int NIBBLES = 4
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [NIBBLE_W*NIBBLES-1:0]   a,
   input  logic [NIBBLE_W*NIBBLES-1:0]   b,
   input  logic                          cin,
`ifdef ADDER_SUB_EN
   input  logic                          sub,
`endif
   output logic                          busy,
   output logic                          done,
   output logic [NIBBLE_W*NIBBLES-1:0]   sum,
   output logic                          cout
);

   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

   state_t                                 state_q;
   logic [IW-1:0]                          idx_q;
   logic                                   cy_q;
   logic [NIBBLES-1:0][NIBBLE_W-1:0]       a_q;
   logic [NIBBLES-1:0][NIBBLE_W-1:0]       b_q;
   logic [NIBBLES-1:0][NIBBLE_W-1:0]       sum_q;
   logic                                   busy_q;
   logic                                   done_q;
   logic                                   cout_q;

   logic [NIBBLE_W-1:0]                    nib_a;
   logic [NIBBLE_W-1:0]                    nib_b;
   logic [NIBBLE_W-1:0]                    cell_s;
   logic                                   cell_co;
   logic                                   cy_init;

`ifdef ADDER_SUB_EN
   logic sub_q;

   // Subtraction is A + ~B + 1, so the cell only ever adds.
   assign nib_b   = sub_q ? ~b_q[idx_q] : b_q[idx_q];
   assign cy_init = sub ? 1'b1 : cin;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_q <= 1'b0;
      end else if (state_q == IDLE && start) begin
         sub_q <= sub;
      end
   end
`else
   assign nib_b   = b_q[idx_q];
   assign cy_init = cin;
`endif

   assign nib_a = a_q[idx_q];

   rca4_cell u_cell (
      .a  (nib_a),
      .b  (nib_b),
      .ci (cy_q),
      .s  (cell_s),
      .co (cell_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cy_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  cy_q    <= cy_init;
                  idx_q   <= '0;
                  sum_q   <= '0;
                  cout_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               sum_q[idx_q] <= cell_s;
               cy_q         <= cell_co;
               if (idx_q == IDX_LAST) begin
                  idx_q   <= '0;
                  cout_q  <= cell_co;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl (NIBBLES=4); sub tests under ADDER_SUB_EN.
module tb_nibble_serial_adder_ctrl;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      int           acc;
   } exp_t;

   exp_t         q[$];
   int           tests = 0;
   int           fails = 0;
   int           cyc = 0;
   int           done_cnt = 0;
   logic         prev_done = 1'b0;
   logic         have_last = 1'b0;
   logic [W-1:0] last_sum = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on the whole operand.
   function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                  input logic ic, input logic is);
      exp_t e;
      logic [W:0] t;
      if (is) begin
         e.s = ia - ib;
         e.c = (ia >= ib);
      end else begin
         t   = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
         e.s = t[W-1:0];
         e.c = t[W];
      end
      e.acc = 0;
      return e;
   endfunction

   always @(negedge rst_n) have_last = 1'b0;

   // Monitor: pops the scoreboard whenever done is presented.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            done_cnt++;
            check("done_pulse_width", {31'b0, prev_done}, 32'd0);
            check("busy_at_done", {31'b0, busy}, 32'd0);
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("sum", {16'b0, sum}, {16'b0, e.s});
               check("cout", {31'b0, cout}, {31'b0, e.c});
               check("latency", cyc - e.acc, N);
            end
            last_sum  = sum;
            have_last = 1'b1;
         end else if (!busy && have_last) begin
            check("sum_hold", {16'b0, sum}, {16'b0, last_sum});
         end
         prev_done = done;
      end else begin
         prev_done = 1'b0;
      end
   end

   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic is);
      exp_t e;
      int n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("issue_timeout_busy", 32'd1, 32'd0);
      a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e = model(ia, ib, ic, is);
      e.acc = cyc;
      q.push_back(e);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((q.size() != 0 || busy) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", q.size(), 0);
   endtask

   initial begin
      #1;
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_done", {31'b0, done}, 0);
      check("rst_sum", {16'b0, sum}, 0);
      check("rst_cout", {31'b0, cout}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      issue(16'h1234, 16'h4321, 1'b0, 1'b0);
      wait_drain();
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_drain();
      issue(16'hFFFF, 16'h0000, 1'b1, 1'b0);
      wait_drain();

      // start held while busy must be dropped, then start in the done cycle is taken
      issue(16'h1234, 16'h4321, 1'b0, 1'b0);
      @(negedge clk);
      a = 16'h0001; b = 16'h0001; start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      begin
         int n = 0;
         while (!done && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("wait_done_timeout", {31'b0, done}, 1);
      end
      issue(16'h0001, 16'h0001, 1'b0, 1'b0);
      wait_drain();

      // reset two cycles after accept abandons the operation
      issue(16'h1234, 16'h4321, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'b0, busy}, 0);
      check("midrst_done", {31'b0, done}, 0);
      check("midrst_sum", {16'b0, sum}, 0);
      check("midrst_cout", {31'b0, cout}, 0);
      q.delete();
      done_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("midrst_no_done", done_cnt, 0);
      issue(16'hABCD, 16'h1111, 1'b1, 1'b0);
      wait_drain();

`ifdef ADDER_SUB_EN
      issue(16'h0005, 16'h0007, 1'b0, 1'b1);
      wait_drain();
      issue(16'h0007, 16'h0005, 1'b1, 1'b1);
      wait_drain();
`endif

      for (int i = 0; i < 25; i++) begin
         logic is;
         is = 1'b0;
`ifdef ADDER_SUB_EN
         is = 1'($urandom_range(0, 1));
`endif
         issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), is);
         if ($urandom_range(0, 2) == 0) begin
            wait_drain();
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      wait_drain();
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
